// File: rtl/alu_ctrl_pkg.sv
// Shared opcodes, state encoding and counter sizing
// for the ALU sequencer and its opcode decoder.
package alu_ctrl_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_LOADI = 5'b00001;
    localparam logic [4:0] OP_STORE = 5'b00010;
    localparam logic [4:0] OP_ADD   = 5'b00011;
    localparam logic [4:0] OP_ADDI  = 5'b00100;
    localparam logic [4:0] OP_SUB   = 5'b00101;
    localparam logic [4:0] OP_AND   = 5'b00110;
    localparam logic [4:0] OP_OR    = 5'b00111;
    localparam logic [4:0] OP_XOR   = 5'b01000;
    localparam logic [4:0] OP_NOT   = 5'b01001;
    localparam logic [4:0] OP_NEG   = 5'b01010;
    localparam logic [4:0] OP_SHL   = 5'b01011;
    localparam logic [4:0] OP_SHR   = 5'b01100;
    localparam logic [4:0] OP_MUL   = 5'b01111;
    localparam logic [4:0] OP_DIV   = 5'b10000;
    localparam logic [4:0] OP_ROL   = 5'b10001;
    localparam logic [4:0] OP_ROR   = 5'b10010;
    localparam logic [4:0] OP_BR    = 5'b10011;
    localparam logic [4:0] NOP_OP   = 5'b11111;

    localparam int CNT_W = 4;

    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic [CNT_W:0]   cyc_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        EXEC,
        RESP
    } state_t;

    function automatic logic isLegal(
        input logic [4:0] op
    );
        return (op <= OP_SHR) ||
               ((op >= OP_MUL) && (op <= OP_BR));
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// Opcode classifier: legality, wide result
// and EXEC latency for one ALU opcode.
module alu_op_decode
    import alu_ctrl_pkg::*;
#(
    parameter int BASE_CYCLES = 1,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic [4:0]   opcode,
    output logic         legal,
    output logic         wide,
    output logic [CNT_W:0] exec_cycles
);

    // Classify the opcode and pick its latency class
    always_comb begin
        legal       = isLegal(opcode);
        wide        = 1'b0;
        exec_cycles = cyc_t'(BASE_CYCLES);
        unique case (opcode)
            OP_MUL: begin
                wide        = 1'b1;
                exec_cycles = cyc_t'(MUL_CYCLES);
            end
            OP_DIV: begin
                wide        = 1'b1;
                exec_cycles = cyc_t'(DIV_CYCLES);
            end
            default: begin
                wide        = 1'b0;
                exec_cycles = cyc_t'(BASE_CYCLES);
            end
        endcase
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU controller: request in, timed
// ALU drive, captured result out over valid/ready.
module alu_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int BASE_CYCLES = 1,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 8
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [4:0]  req_op,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_flag,
    output logic [4:0]  alu_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic        alu_flag,
    input  logic [31:0] alu_z_low,
    input  logic [31:0] alu_z_high,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_low,
    output logic [31:0] rsp_high,
    output logic        rsp_wide,
    output logic        rsp_err
);

    state_t     state;
    state_t     nextState;
    logic [4:0] opReg;
    logic [4:0] decOp;
    cnt_t       cnt;
    logic       decLegal;
    logic       decWide;
    cyc_t       decCycles;
    logic       accept;
    logic       divZero;
    logic       goExec;
    logic       done;

    // In IDLE the decoder classifies the incoming
    // request; afterwards it describes the held op.
    assign decOp = (state == IDLE) ? req_op : opReg;

    alu_op_decode #(
        .BASE_CYCLES (BASE_CYCLES),
        .MUL_CYCLES  (MUL_CYCLES),
        .DIV_CYCLES  (DIV_CYCLES)
    ) uDecode (
        .opcode      (decOp),
        .legal       (decLegal),
        .wide        (decWide),
        .exec_cycles (decCycles)
    );

    assign accept  = req_valid && req_ready;
    assign divZero = (req_op == OP_DIV) && (req_b == 32'd0);
    assign goExec  = decLegal && !divZero;
    assign done    = (state == EXEC) && (cnt == '0);

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next state and handshake/ALU opcode outputs
    always_comb begin
        nextState = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        alu_op    = NOP_OP;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    nextState = goExec ? SETUP : RESP;
                end
            end
            SETUP: begin
                nextState = EXEC;
            end
            EXEC: begin
                alu_op = opReg;
                if (cnt == '0) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    nextState = IDLE;
                end
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // Operand latch, latency counter and result capture
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            opReg    <= NOP_OP;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_flag <= 1'b0;
            cnt      <= '0;
            rsp_low  <= '0;
            rsp_high <= '0;
            rsp_wide <= 1'b0;
            rsp_err  <= 1'b0;
        end else begin
            if (accept) begin
                if (goExec) begin
                    opReg    <= req_op;
                    alu_a    <= req_a;
                    alu_b    <= req_b;
                    alu_flag <= req_flag;
                end else begin
                    rsp_low  <= '0;
                    rsp_high <= divZero ? req_a : '0;
                    rsp_wide <= 1'b0;
                    rsp_err  <= 1'b1;
                end
            end
            if (state == SETUP) begin
                cnt <= cnt_t'(decCycles - cyc_t'(1));
            end else if ((state == EXEC) && (cnt != '0)) begin
                cnt <= cnt - cnt_t'(1);
            end
            // High word of single-word ops is stale
            // in the ALU, so it is zeroed here.
            if (done) begin
                rsp_low  <= alu_z_low;
                rsp_high <= decWide ? alu_z_high : '0;
                rsp_wide <= decWide;
                rsp_err  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: opcode-change-driven ALU
// model, directed vector table and random ops.
module tb_alu_sequencer;
    import alu_ctrl_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [4:0]  req_op = NOP_OP;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic        req_flag = 1'b0;
    logic [4:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_flag;
    logic [31:0] alu_z_low = 32'hdead_beef;
    logic [31:0] alu_z_high = 32'hcafe_f00d;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_low;
    logic [31:0] rsp_high;
    logic        rsp_wide;
    logic        rsp_err;

    int checks = 0;
    int failures = 0;

    alu_sequencer #(
        .BASE_CYCLES (1),
        .MUL_CYCLES  (4),
        .DIV_CYCLES  (8)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_flag   (req_flag),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_flag   (alu_flag),
        .alu_z_low  (alu_z_low),
        .alu_z_high (alu_z_high),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_low    (rsp_low),
        .rsp_high   (rsp_high),
        .rsp_wide   (rsp_wide),
        .rsp_err    (rsp_err)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] aluCompute(
        input logic [4:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        f
    );
        logic [4:0] s;
        s = b[4:0];
        case (op)
            OP_LOAD, OP_STORE, OP_ADD, OP_ADDI:
                return {32'd0, a + b};
            OP_LOADI: return {32'd0, b};
            OP_SUB:   return {32'd0, a - b};
            OP_AND:   return {32'd0, a & b};
            OP_OR:    return {32'd0, a | b};
            OP_XOR:   return {32'd0, a ^ b};
            OP_NOT:   return {32'd0, ~a};
            OP_NEG:   return {32'd0, 32'd0 - a};
            OP_SHL:   return {32'd0, a << s};
            OP_SHR:   return {32'd0, a >> s};
            OP_ROL:   return {32'd0, (a << s) | (a >> (6'd32 - s))};
            OP_ROR:   return {32'd0, (a >> s) | (a << (6'd32 - s))};
            OP_MUL:   return {32'd0, a} * {32'd0, b};
            OP_DIV:   return (b == 0) ? 64'd0 : {a % b, a / b};
            OP_BR:    return {32'd0, f ? a + b : a};
            default:  return 64'd0;
        endcase
    endfunction

    // ALU model: recomputes only when the opcode changes;
    // the high word is only written by mul and div.
    always @(alu_op) begin
        logic [63:0] r;
        if (alu_op != NOP_OP) begin
            r = aluCompute(alu_op, alu_a, alu_b, alu_flag);
            alu_z_low = r[31:0];
            if (alu_op == OP_MUL || alu_op == OP_DIV) begin
                alu_z_high = r[63:32];
            end
        end
    end

    typedef struct packed {
        logic [31:0] lo;
        logic [31:0] hi;
        logic        wd;
        logic        er;
        logic [7:0]  lat;
    } exp_t;

    function automatic exp_t refModel(
        input logic [4:0]  op,
        input logic [31:0] a,
        input logic [31:0] b,
        input logic        f
    );
        exp_t e;
        logic [63:0] r;
        int n;
        bit ok;
        ok = (op <= 5'd12) || (op >= 5'd15 && op <= 5'd19);
        e = '0;
        if (!ok) begin
            e.er = 1'b1;
            e.lat = 8'd1;
        end else if (op == OP_DIV && b == 0) begin
            e.er = 1'b1;
            e.hi = a;
            e.lat = 8'd1;
        end else begin
            r = aluCompute(op, a, b, f);
            n = (op == OP_MUL) ? 4 : (op == OP_DIV) ? 8 : 1;
            e.wd = (op == OP_MUL || op == OP_DIV);
            e.lo = r[31:0];
            e.hi = e.wd ? r[63:32] : 32'd0;
            e.lat = 8'(n + 2);
        end
        return e;
    endfunction

    task automatic check(
        input string       name,
        input logic [79:0] got,
        input logic [79:0] exp
    );
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic checkReset(input string tag);
        check({tag, "_ctrl"},
              {req_ready, rsp_valid, alu_op, alu_flag,
               rsp_wide, rsp_err},
              {1'b1, 1'b0, NOP_OP, 1'b0, 1'b0, 1'b0});
        check({tag, "_alu"}, {alu_a, alu_b}, 64'd0);
        check({tag, "_rsp"}, {rsp_low, rsp_high}, 64'd0);
    endtask

    task automatic runOp(
        input  logic [4:0]  op,
        input  logic [31:0] a,
        input  logic [31:0] b,
        input  logic        f,
        input  int          hold,
        output logic [31:0] lo,
        output logic [31:0] hi,
        output logic        wd,
        output logic        er,
        output int          lat,
        output int          execCnt,
        output logic        nopAtResp
    );
        int n;
        logic stable;
        n = 0;
        @(negedge clock);
        while (!req_ready && n < 50) begin
            @(negedge clock);
            n++;
        end
        if (!req_ready) check("readyTimeout", 0, 1);
        req_op = op;
        req_a = a;
        req_b = b;
        req_flag = f;
        req_valid = 1'b1;
        rsp_ready = (hold == 0);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_a = $urandom;
        req_b = $urandom;
        req_flag = ~f;
        lat = 1;
        execCnt = 0;
        while (!rsp_valid && lat < 40) begin
            if (alu_op == op && alu_a == a &&
                alu_b == b && alu_flag == f)
                execCnt++;
            @(posedge clock);
            #1;
            lat++;
        end
        lo = rsp_low;
        hi = rsp_high;
        wd = rsp_wide;
        er = rsp_err;
        nopAtResp = (alu_op == NOP_OP);
        if (hold > 0) begin
            stable = 1'b1;
            req_op = OP_ADD;
            req_valid = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(posedge clock);
                #1;
                if (!rsp_valid || rsp_low !== lo ||
                    rsp_high !== hi || rsp_wide !== wd ||
                    rsp_err !== er || req_ready)
                    stable = 1'b0;
            end
            check("holdStable", stable, 1'b1);
            @(negedge clock);
            req_valid = 1'b0;
            rsp_ready = 1'b1;
        end
        @(posedge clock);
        #1;
        check("postHandshake", {rsp_valid, req_ready}, 2'b01);
        rsp_ready = 1'b0;
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        f;
        int          hold;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        wd;
        logic        er;
        int          lat;
    } vec_t;

    initial begin
        vec_t        vecs[$];
        vec_t        v;
        exp_t        e;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        wd;
        logic        er;
        logic        nop;
        logic        seen;
        int          lat;
        int          ex;
        logic [4:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rf;
        int          rh;

        vecs.push_back('{OP_ADD, 7, 5, 0, 0,
                         12, 0, 0, 0, 3});
        vecs.push_back('{OP_MUL, 32'h1_0000, 32'h1_0000, 0, 0,
                         0, 1, 1, 0, 6});
        vecs.push_back('{OP_ADD, 1, 2, 0, 0,
                         3, 0, 0, 0, 3});
        vecs.push_back('{OP_DIV, 100, 0, 0, 0,
                         0, 100, 0, 1, 1});
        vecs.push_back('{OP_DIV, 100, 7, 0, 0,
                         14, 2, 1, 0, 10});
        vecs.push_back('{OP_SUB, 9, 4, 0, 5,
                         5, 0, 0, 0, 3});
        vecs.push_back('{OP_SUB, 9, 4, 0, 0,
                         5, 0, 0, 0, 3});
        vecs.push_back('{5'b01101, 5, 6, 0, 0,
                         0, 0, 0, 1, 1});
        vecs.push_back('{OP_BR, 10, 3, 1, 0,
                         13, 0, 0, 0, 3});
        vecs.push_back('{OP_BR, 10, 3, 0, 0,
                         10, 0, 0, 0, 3});
        vecs.push_back('{NOP_OP, 1, 1, 0, 0,
                         0, 0, 0, 1, 1});
        vecs.push_back('{5'b10100, 3, 0, 0, 1,
                         0, 0, 0, 1, 1});
        vecs.push_back('{OP_MUL, 32'hffff_ffff, 2, 0, 0,
                         32'hffff_fffe, 1, 1, 0, 6});

        #2 reset_n = 1'b0;
        #10;
        checkReset("reset");
        @(negedge clock);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            runOp(v.op, v.a, v.b, v.f, v.hold,
                  lo, hi, wd, er, lat, ex, nop);
            check($sformatf("vec%0d_low", i), lo, v.lo);
            check($sformatf("vec%0d_high", i), hi, v.hi);
            check($sformatf("vec%0d_flags", i),
                  {wd, er}, {v.wd, v.er});
            check($sformatf("vec%0d_lat", i), lat, v.lat);
            check($sformatf("vec%0d_exec", i), ex,
                  v.er ? 0 : v.lat - 2);
            check($sformatf("vec%0d_respNop", i), nop, 1'b1);
        end

        @(negedge clock);
        req_op = OP_DIV;
        req_a = 100;
        req_b = 7;
        req_valid = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        repeat (4) @(posedge clock);
        #3;
        check("midDivExec", alu_op, OP_DIV);
        reset_n = 1'b0;
        #1;
        checkReset("midReset");
        @(negedge clock);
        reset_n = 1'b1;
        seen = 1'b0;
        repeat (12) begin
            @(posedge clock);
            #1;
            if (rsp_valid) seen = 1'b1;
        end
        check("noRspAfterReset", seen, 1'b0);
        rsp_ready = 1'b0;
        runOp(OP_ADD, 1, 1, 0, 0,
              lo, hi, wd, er, lat, ex, nop);
        check("postReset_add",
              {lo, hi, wd, er, 8'(lat)},
              {32'd2, 32'd0, 1'b0, 1'b0, 8'd3});

        for (int k = 0; k < 40; k++) begin
            rop = 5'($urandom_range(0, 31));
            ra = $urandom;
            rb = $urandom;
            rf = 1'($urandom_range(0, 1));
            rh = $urandom_range(0, 2);
            if (rop == OP_DIV && $urandom_range(0, 2) == 0)
                rb = 0;
            e = refModel(rop, ra, rb, rf);
            runOp(rop, ra, rb, rf, rh,
                  lo, hi, wd, er, lat, ex, nop);
            check($sformatf("rand%0d_op%0h", k, rop),
                  {lo, hi, wd, er, 8'(lat)}, e);
            check($sformatf("rand%0d_exec", k), ex,
                  e.er ? 0 : int'(e.lat) - 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d",
                 checks, failures);
        $finish;
    end

endmodule
